// File: rtl/regfile_mp.sv
// regfile_mp: parametrised multi-read-port integer register file with
// optional write-to-read bypass, asynchronous clear and a pending-write
// scoreboard used by decode to detect RAW hazards.
module regfile_mp #(
  parameter int XLEN     = 32,
  parameter int NREG     = 32,
  parameter int NRP      = 2,
  parameter int BYPASS   = 1,
  parameter int ZERO_REG = 1,
  localparam int AW      = $clog2(NREG)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [NRP*AW-1:0]   ra,
  output logic [NRP*XLEN-1:0] rd,
  input  logic                we,
  input  logic [AW-1:0]       wa,
  input  logic [XLEN-1:0]     wd,
  input  logic                iss_v,
  input  logic [AW-1:0]       iss_rd,
  output logic [NRP-1:0]      busy,
  output logic [AW:0]         pend_cnt
);

  // Architectural state
  logic [XLEN-1:0] x_reg [NREG];
  logic [NREG-1:0] pending_reg;
  logic [NREG-1:0] pending_next;
  logic [AW:0]     pend_cnt_reg;
  logic [AW:0]     pend_cnt_next;

  // Qualified write and issue strobes. Enable and address are checked as
  // separate terms so a write of data to x0 never sneaks through.
  logic wr_ok;
  logic iss_ok;

  assign wr_ok  = we    && ((ZERO_REG == 0) || (wa     != '0));
  assign iss_ok = iss_v && ((ZERO_REG == 0) || (iss_rd != '0));

  // Register array: cleared by reset, written from writeback.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int r = 0; r < NREG; r++) begin
        x_reg[r] <= '0;
      end
    end else if (wr_ok) begin
      x_reg[wa] <= wd;
    end
  end

  // Scoreboard next state per register. An issue to the same register as a
  // completing write wins: the newer producer now owns that register.
  genvar gi;
  generate
    for (gi = 0; gi < NREG; gi++) begin : g_sb
      logic sb_set;
      logic sb_clr;
      assign sb_set = iss_ok && (iss_rd == AW'(gi));
      assign sb_clr = wr_ok  && (wa     == AW'(gi));
      assign pending_next[gi] = sb_set || (pending_reg[gi] && !sb_clr);
    end
  endgenerate

  // Population count of the next pending vector, so the registered count
  // always tracks the registered vector exactly.
  always_comb begin
    pend_cnt_next = '0;
    for (int r = 0; r < NREG; r++) begin
      pend_cnt_next = pend_cnt_next + (AW+1)'(pending_next[r]);
    end
  end

  // Scoreboard state and its occupancy count update together.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pending_reg  <= '0;
      pend_cnt_reg <= '0;
    end else begin
      pending_reg  <= pending_next;
      pend_cnt_reg <= pend_cnt_next;
    end
  end

  assign pend_cnt = pend_cnt_reg;

  // Independent combinational read ports with optional same-cycle forwarding.
  generate
    for (gi = 0; gi < NRP; gi++) begin : g_rp
      logic [AW-1:0] ra_i;
      logic          zero_hit;
      logic          byp_hit;

      assign ra_i     = ra[gi*AW +: AW];
      assign zero_hit = (ZERO_REG != 0) && (ra_i == '0);
      assign byp_hit  = (BYPASS != 0) && wr_ok && (wa == ra_i);

      assign rd[gi*XLEN +: XLEN] = zero_hit ? '0 :
                                   byp_hit  ? wd : x_reg[ra_i];

      // A forwarded write already satisfies the consumer, so it is not busy.
      assign busy[gi] = !zero_hit && pending_reg[ra_i] && !byp_hit;
    end
  endgenerate

endmodule

// File: tb/tb_regfile_mp.sv
// tb_regfile_mp: directed table plus hand sequences for regfile_mp, covering
// reset, x0 protection, bypass on/off, scoreboard timing and a wide sweep.
module tb_regfile_mp;

  logic clk = 1'b0;
  logic rst;

  always #5 clk = ~clk;

  // Default instance: XLEN=32, NREG=32, NRP=2, BYPASS=1, ZERO_REG=1
  logic [9:0]  ra_m;
  logic [63:0] rd_m;
  logic        we_m;
  logic [4:0]  wa_m;
  logic [31:0] wd_m;
  logic        iss_v_m;
  logic [4:0]  iss_rd_m;
  logic [1:0]  busy_m;
  logic [5:0]  cnt_m;

  regfile_mp dut_m (
    .clk(clk), .rst(rst), .ra(ra_m), .rd(rd_m), .we(we_m), .wa(wa_m), .wd(wd_m),
    .iss_v(iss_v_m), .iss_rd(iss_rd_m), .busy(busy_m), .pend_cnt(cnt_m)
  );

  // Bypass disabled instance
  logic [9:0]  ra_n;
  logic [63:0] rd_n;
  logic        we_n;
  logic [4:0]  wa_n;
  logic [31:0] wd_n;
  logic        iss_v_n;
  logic [4:0]  iss_rd_n;
  logic [1:0]  busy_n;
  logic [5:0]  cnt_n;

  regfile_mp #(.BYPASS(0)) dut_n (
    .clk(clk), .rst(rst), .ra(ra_n), .rd(rd_n), .we(we_n), .wa(wa_n), .wd(wd_n),
    .iss_v(iss_v_n), .iss_rd(iss_rd_n), .busy(busy_n), .pend_cnt(cnt_n)
  );

  // Wide instance: XLEN=64, NREG=16, NRP=3
  logic [11:0]  ra_w;
  logic [191:0] rd_w;
  logic         we_w;
  logic [3:0]   wa_w;
  logic [63:0]  wd_w;
  logic         iss_v_w;
  logic [3:0]   iss_rd_w;
  logic [2:0]   busy_w;
  logic [4:0]   cnt_w;

  regfile_mp #(.XLEN(64), .NREG(16), .NRP(3)) dut_w (
    .clk(clk), .rst(rst), .ra(ra_w), .rd(rd_w), .we(we_w), .wa(wa_w), .wd(wd_w),
    .iss_v(iss_v_w), .iss_rd(iss_rd_w), .busy(busy_w), .pend_cnt(cnt_w)
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [255:0] act, input logic [255:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  typedef struct {
    logic        we;
    logic [4:0]  wa;
    logic [31:0] wd;
    logic        iv;
    logic [4:0]  ir;
    logic [4:0]  a0;
    logic [4:0]  a1;
    logic [31:0] e0;
    logic [31:0] e1;
    logic [1:0]  eb;
    logic [5:0]  ec;
  } vec_t;

  function automatic vec_t mk(logic we, logic [4:0] wa, logic [31:0] wd, logic iv,
                              logic [4:0] ir, logic [4:0] a0, logic [4:0] a1,
                              logic [31:0] e0, logic [31:0] e1, logic [1:0] eb,
                              logic [5:0] ec);
    vec_t v;
    v.we = we; v.wa = wa; v.wd = wd; v.iv = iv; v.ir = ir;
    v.a0 = a0; v.a1 = a1; v.e0 = e0; v.e1 = e1; v.eb = eb; v.ec = ec;
    return v;
  endfunction

  localparam int NV = 18;
  vec_t tv [NV];

  logic [63:0]  model [16];
  logic [191:0] exp_w;
  logic [3:0]   a_w;

  initial begin
    // Expected outputs are for the combinational view during that cycle,
    // before the closing edge.
    //          we wa  wd            iv ir  a0  a1  rd0           rd1           busy   cnt
    tv[0]  = mk(0, 0,  32'h0,        0, 0,  0,  5,  32'h0,        32'h0,        2'b00, 0);
    tv[1]  = mk(1, 5,  32'hDEADBEEF, 0, 0,  5,  5,  32'hDEADBEEF, 32'hDEADBEEF, 2'b00, 0);
    tv[2]  = mk(0, 0,  32'h0,        0, 0,  5,  0,  32'hDEADBEEF, 32'h0,        2'b00, 0);
    tv[3]  = mk(1, 0,  32'hFFFFFFFF, 1, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0);
    tv[4]  = mk(0, 0,  32'h0,        0, 0,  0,  0,  32'h0,        32'h0,        2'b00, 0);
    tv[5]  = mk(0, 0,  32'h0,        1, 3,  3,  5,  32'h0,        32'hDEADBEEF, 2'b00, 0);
    tv[6]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h0,        32'h0,        2'b01, 1);
    tv[7]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h0,        32'h0,        2'b01, 1);
    tv[8]  = mk(1, 3,  32'h42,       0, 0,  3,  3,  32'h42,       32'h42,       2'b00, 1);
    tv[9]  = mk(0, 0,  32'h0,        0, 0,  3,  0,  32'h42,       32'h0,        2'b00, 0);
    tv[10] = mk(0, 0,  32'h0,        1, 4,  4,  0,  32'h0,        32'h0,        2'b00, 0);
    tv[11] = mk(1, 4,  32'h77,       1, 4,  4,  4,  32'h77,       32'h77,       2'b00, 1);
    tv[12] = mk(0, 0,  32'h0,        0, 0,  4,  4,  32'h77,       32'h77,       2'b11, 1);
    tv[13] = mk(0, 0,  32'h0,        1, 6,  4,  6,  32'h77,       32'h0,        2'b01, 1);
    tv[14] = mk(0, 0,  32'h0,        0, 0,  6,  4,  32'h0,        32'h77,       2'b11, 2);
    tv[15] = mk(1, 6,  32'h66,       0, 0,  6,  4,  32'h66,       32'h77,       2'b10, 2);
    tv[16] = mk(1, 7,  32'h1234,     0, 0,  7,  6,  32'h1234,     32'h66,       2'b00, 1);
    tv[17] = mk(0, 7,  32'hABCD,     0, 0,  7,  4,  32'h1234,     32'h77,       2'b10, 1);

    ra_m = '0; we_m = 0; wa_m = '0; wd_m = '0; iss_v_m = 0; iss_rd_m = '0;
    ra_n = '0; we_n = 0; wa_n = '0; wd_n = '0; iss_v_n = 0; iss_rd_n = '0;
    ra_w = '0; we_w = 0; wa_w = '0; wd_w = '0; iss_v_w = 0; iss_rd_w = '0;
    rst = 1'b1;

    // Reset state, before any clock edge
    #2;
    check("reset_rd_m", rd_m, 0);
    check("reset_busy_m", busy_m, 0);
    check("reset_cnt_m", cnt_m, 0);
    check("reset_rd_w", rd_w, 0);
    check("reset_cnt_w", cnt_w, 0);
    $display("[TB] reset: rd_m=%0h busy_m=%0b cnt_m=%0d", rd_m, busy_m, cnt_m);

    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // Table-driven vectors on the default instance
    for (int i = 0; i < NV; i++) begin
      we_m = tv[i].we; wa_m = tv[i].wa; wd_m = tv[i].wd;
      iss_v_m = tv[i].iv; iss_rd_m = tv[i].ir; ra_m = {tv[i].a1, tv[i].a0};
      @(negedge clk);
      check($sformatf("vec%0d_rd0", i), rd_m[31:0], tv[i].e0);
      check($sformatf("vec%0d_rd1", i), rd_m[63:32], tv[i].e1);
      check($sformatf("vec%0d_busy", i), busy_m, tv[i].eb);
      check($sformatf("vec%0d_cnt", i), cnt_m, tv[i].ec);
      $display("[TB] vec %0d: we=%0b wa=%0d iss=%0b/%0d ra=%0d,%0d rd=%0h,%0h busy=%0b cnt=%0d",
               i, we_m, wa_m, iss_v_m, iss_rd_m, tv[i].a0, tv[i].a1,
               rd_m[31:0], rd_m[63:32], busy_m, cnt_m);
      @(posedge clk);
      #1;
    end
    we_m = 0; iss_v_m = 0;

    // Asynchronous reset asserted mid-cycle while a write is in flight
    we_m = 1; wa_m = 5; wd_m = 32'hDEADBEEF; ra_m = {5'd4, 5'd7};
    #2 rst = 1'b1;
    #1;
    check("async_rst_rd", rd_m, 0);
    check("async_rst_busy", busy_m, 0);
    check("async_rst_cnt", cnt_m, 0);
    $display("[TB] async reset: rd=%0h busy=%0b cnt=%0d", rd_m, busy_m, cnt_m);
    @(posedge clk);
    #1 rst = 1'b0;
    we_m = 0; ra_m = {5'd4, 5'd5};
    @(negedge clk);
    check("post_rst_x5", rd_m[31:0], 0);
    check("post_rst_x4", rd_m[63:32], 0);
    check("post_rst_cnt", cnt_m, 0);
    $display("[TB] after reset: x5=%0h x4=%0h cnt=%0d", rd_m[31:0], rd_m[63:32], cnt_m);
    @(posedge clk);
    #1;

    // Bypass disabled: writes appear one cycle later, busy clears a cycle later
    ra_n = {5'd9, 5'd9};
    we_n = 1; wa_n = 9; wd_n = 32'h11111111;
    @(negedge clk);
    check("nb_first_old", rd_n, 0);
    $display("[TB] nb write 11111111: rd=%0h", rd_n);
    @(posedge clk); #1;
    wd_n = 32'hA5A5A5A5;
    @(negedge clk);
    check("nb_same_cycle_old", rd_n, {2{32'h11111111}});
    $display("[TB] nb write A5A5A5A5: rd=%0h", rd_n);
    @(posedge clk); #1;
    we_n = 0;
    @(negedge clk);
    check("nb_after_edge", rd_n, {2{32'hA5A5A5A5}});
    $display("[TB] nb idle: rd=%0h", rd_n);
    @(posedge clk); #1;
    iss_v_n = 1; iss_rd_n = 9;
    @(negedge clk);
    check("nb_issue_busy", busy_n, 2'b00);
    $display("[TB] nb issue x9: busy=%0b", busy_n);
    @(posedge clk); #1;
    iss_v_n = 0; we_n = 1; wa_n = 9; wd_n = 32'h5;
    @(negedge clk);
    check("nb_wb_busy", busy_n, 2'b11);
    check("nb_wb_rd", rd_n, {2{32'hA5A5A5A5}});
    check("nb_wb_cnt", cnt_n, 1);
    $display("[TB] nb writeback x9: busy=%0b rd=%0h cnt=%0d", busy_n, rd_n, cnt_n);
    @(posedge clk); #1;
    we_n = 0;
    @(negedge clk);
    check("nb_cleared_busy", busy_n, 2'b00);
    check("nb_cleared_rd", rd_n, {2{32'h5}});
    check("nb_cleared_cnt", cnt_n, 0);
    $display("[TB] nb after writeback: busy=%0b rd=%0h cnt=%0d", busy_n, rd_n, cnt_n);
    @(posedge clk); #1;

    // Wide sweep: fill every register, then random reads with some writes
    for (int r = 0; r < 16; r++) begin
      we_w = 1; wa_w = 4'(r); wd_w = {$urandom(), $urandom()};
      @(posedge clk); #1;
      model[r] = (r == 0) ? 64'h0 : wd_w;
    end
    we_w = 0;
    for (int c = 0; c < 1000; c++) begin
      ra_w = 12'($urandom());
      if ($urandom_range(3) == 0) begin
        we_w = 1; wa_w = 4'($urandom()); wd_w = {$urandom(), $urandom()};
      end else begin
        we_w = 0;
      end
      for (int p = 0; p < 3; p++) begin
        a_w = ra_w[p*4 +: 4];
        if (a_w == 0)
          exp_w[p*64 +: 64] = 64'h0;
        else if (we_w && wa_w == a_w)
          exp_w[p*64 +: 64] = wd_w;
        else
          exp_w[p*64 +: 64] = model[a_w];
      end
      @(negedge clk);
      check($sformatf("sweep%0d", c), rd_w, exp_w);
      $display("[TB] sweep %0d: ra=%0h we=%0b wa=%0d", c, ra_w, we_w, wa_w);
      @(posedge clk); #1;
      if (we_w && wa_w != 0) model[wa_w] = wd_w;
    end
    we_w = 0;

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
